// File: rtl/adc_readout_pkg.sv
// adc_readout_pkg: packed-word field layout and drain FSM states for the ADC FIFO drain path
package adc_readout_pkg;
  localparam int WORD_W = 32;
  localparam int CH_LSB = 28;
  localparam int CH_W = 4;
  localparam int WORD_HALF_BIT = 27;
  localparam int HI_LSB = 12;
  localparam int LO_LSB = 0;
  localparam int FIELD_W = 12;
  typedef enum logic [2:0] {IDLE, RD0, CAP0, RD1, CAP1, OUT} drain_state_t;
  function automatic logic [WORD_W-1:0] pack_word(input logic [CH_W-1:0] ch, input logic half,
                                                  input logic [FIELD_W-1:0] hi, input logic [FIELD_W-1:0] lo);
    logic [WORD_W-1:0] w;
    w = '0;
    w[CH_LSB +: CH_W] = ch;
    w[WORD_HALF_BIT] = half;
    w[HI_LSB +: FIELD_W] = hi;
    w[LO_LSB +: FIELD_W] = lo;
    return w;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after pointer
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);
  logic [IW-1:0] c;
  always_comb begin
    index = '0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(pointer) + k) % N);
      if (req[c]) index = c;
    end
  end
  assign valid = |req;
  assign grant = valid ? N'(1) << index : '0;
endmodule

// File: rtl/adc_fifo_drain_packer.sv
// adc_fifo_drain_packer: round-robin drains channel FIFOs and packs sample pairs into AXI-Stream words
module adc_fifo_drain_packer
  import adc_readout_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH = 12,
  parameter int BURST_LEN = 16,
  localparam int AW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic [NUM_CHANNELS-1:0] ch_mask,
  input  logic                    clear_status,
  output logic [AW-1:0]           fifo_addr,
  output logic [NUM_CHANNELS-1:0] fifo_rd_en,
  input  logic [NUM_CHANNELS-1:0] fifo_not_empty,
  input  logic [NUM_CHANNELS-1:0] fifo_full,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  output logic [31:0]             m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [NUM_CHANNELS-1:0] overflow_sticky,
  output logic                    busy
);
  localparam int CW = $clog2(BURST_LEN + 1);
  drain_state_t state;
  logic [AW-1:0] ptr, gnt_idx;
  logic [NUM_CHANNELS-1:0] sel, gnt_oh;
  logic gnt_any, stop;
  logic [CW-1:0] count, count_nxt;
  logic [FIELD_W-1:0] lo, din;
  assign din = FIELD_W'(fifo_dout);
  assign count_nxt = count + 1'b1;
  // fifo_not_empty already reflects the pop of the sample being captured
  assign stop = count_nxt == CW'(BURST_LEN) || !fifo_not_empty[fifo_addr] || !enable;
  assign busy = state != IDLE;
  rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .req(fifo_not_empty & ch_mask),
    .pointer(ptr),
    .grant(gnt_oh),
    .index(gnt_idx),
    .valid(gnt_any)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      ptr <= AW'(NUM_CHANNELS - 1);
      fifo_addr <= '0;
      sel <= '0;
      fifo_rd_en <= '0;
      count <= '0;
      lo <= '0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      overflow_sticky <= '0;
    end else begin
      overflow_sticky <= (overflow_sticky & ~{NUM_CHANNELS{clear_status}}) | fifo_full;
      case (state)
        IDLE: if (enable && gnt_any) begin
          fifo_addr <= gnt_idx;
          ptr <= gnt_idx;
          sel <= gnt_oh;
          fifo_rd_en <= gnt_oh;
          count <= '0;
          state <= RD0;
        end
        RD0: begin
          fifo_rd_en <= '0;
          state <= CAP0;
        end
        CAP0: begin
          lo <= din;
          count <= count_nxt;
          if (stop) begin
            m_axis_tdata <= pack_word(CH_W'(fifo_addr), 1'b1, '0, din);
            m_axis_tlast <= 1'b1;
            m_axis_tvalid <= 1'b1;
            state <= OUT;
          end else begin
            fifo_rd_en <= sel;
            state <= RD1;
          end
        end
        RD1: begin
          fifo_rd_en <= '0;
          state <= CAP1;
        end
        CAP1: begin
          count <= count_nxt;
          m_axis_tdata <= pack_word(CH_W'(fifo_addr), 1'b0, din, lo);
          m_axis_tlast <= stop;
          m_axis_tvalid <= 1'b1;
          state <= OUT;
        end
        OUT: if (m_axis_tready) begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast <= 1'b0;
          fifo_rd_en <= m_axis_tlast ? '0 : sel;
          state <= m_axis_tlast ? IDLE : RD0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_fifo_drain_packer.sv
// tb_adc_fifo_drain_packer: FIFO model plus scoreboard of expected packed words
module tb_adc_fifo_drain_packer;
  logic clk = 1'b0, rstn = 1'b0, enable = 1'b0, clear_status = 1'b0, tready = 1'b0;
  logic [3:0] ch_mask = 4'hf, full = '0, ne = '0, rd_en;
  logic [1:0] addr;
  logic [11:0] dout;
  logic [11:0] dreg [4];
  logic [31:0] tdata;
  logic tvalid, tlast, busy;
  logic [3:0] sticky;
  logic [11:0] fq [4][$];
  logic [32:0] sb [$];
  logic ld_go = 1'b0;
  int ld_ch = 0, ld_n = 0, ld_base = 0, ld_step = 0;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  adc_fifo_drain_packer dut (
    .clk(clk), .rstn(rstn), .enable(enable), .ch_mask(ch_mask), .clear_status(clear_status),
    .fifo_addr(addr), .fifo_rd_en(rd_en), .fifo_not_empty(ne), .fifo_full(full), .fifo_dout(dout),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
    .overflow_sticky(sticky), .busy(busy)
  );

  assign dout = dreg[addr];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (rd_en[i] && fq[i].size() != 0) dreg[i] <= fq[i].pop_front();
    if (ld_go)
      for (int k = 0; k < ld_n; k++) fq[ld_ch].push_back(12'(ld_base + k * ld_step));
    for (int i = 0; i < 4; i++) ne[i] <= fq[i].size() != 0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (rstn && tvalid && tready) begin
      if (sb.size() == 0) chk("sb_empty", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk("tdata", 64'(tdata), 64'(e[31:0]));
        chk("tlast", 64'(tlast), 64'(e[32]));
      end
    end
    if (|(rd_en & ~ne)) chk("rd_on_empty", 64'(rd_en & ~ne), 64'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int n, input int base, input int stp);
    tick();
    ld_ch = ch; ld_n = n; ld_base = base; ld_step = stp; ld_go = 1'b1;
    tick();
    ld_go = 1'b0;
  endtask

  task automatic exp_burst(input int ch, input int base, input int stp, input int start, input int n);
    for (int k = 0; k < n; k += 2) begin
      logic [11:0] a, b;
      logic half, last;
      a = 12'(base + (start + k) * stp);
      half = k + 1 >= n;
      b = half ? 12'd0 : 12'(base + (start + k + 1) * stp);
      last = k + 2 >= n;
      sb.push_back({last, 4'(ch), half, 3'b000, b, a});
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_rd(input string tag, input int cnt);
    int seen = 0, t = 0;
    while (seen < cnt && t < 200) begin
      @(negedge clk);
      t++;
      if (rd_en != 0) seen++;
    end
    chk(tag, 64'(seen), 64'(cnt));
  endtask

  task automatic do_reset;
    rstn = 1'b0; enable = 1'b0; tready = 1'b0; clear_status = 1'b0; full = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sticky", 64'(sticky), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic l;
    int t;
    do_reset();
    // ch2, four samples, two full words
    load(2, 4, 'h111, 'h111);
    sb.push_back({1'b0, 32'h2022_2111});
    sb.push_back({1'b1, 32'h2044_4333});
    tready = 1'b1; enable = 1'b1;
    wait_idle("t1_drain");
    enable = 1'b0;
    // ch0, three samples, trailing half word
    load(0, 3, 'haaa, 'h111);
    sb.push_back({1'b0, 32'h00bb_baaa});
    sb.push_back({1'b1, 32'h0800_0ccc});
    enable = 1'b1;
    wait_idle("t2_drain");
    enable = 1'b0;
    // all channels, 40 samples each, round-robin from ch0 after reset
    do_reset();
    for (int c = 0; c < 4; c++) load(c, 40, (c << 8) + 'h10, 1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) exp_burst(c, (c << 8) + 'h10, 1, r * 16, r < 2 ? 16 : 8);
    tready = 1'b1; enable = 1'b1;
    wait_idle("t3_drain");
    enable = 1'b0;
    for (int c = 0; c < 4; c++) chk("t3_fifo_left", 64'(fq[c].size()), 64'd0);
    // back-pressure in OUT
    load(1, 4, 'h321, 'h101);
    exp_burst(1, 'h321, 'h101, 0, 4);
    tready = 1'b0; enable = 1'b1;
    t = 0;
    while (!tvalid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t4_valid", 64'(tvalid), 64'd1);
    d = tdata; l = tlast;
    repeat (10) begin
      @(negedge clk);
      chk("t4_tdata_hold", 64'(tdata), 64'(d));
      chk("t4_tlast_hold", 64'(tlast), 64'(l));
      chk("t4_no_rd", 64'(rd_en), 64'd0);
    end
    tick();
    tready = 1'b1;
    wait_idle("t4_drain");
    enable = 1'b0;
    chk("t4_fifo_left", 64'(fq[1].size()), 64'd0);
    // enable drops during CAP0 of the second word
    load(1, 6, 'h050, 'h010);
    exp_burst(1, 'h050, 'h010, 0, 3);
    enable = 1'b1;
    wait_rd("t5_rd", 3);
    tick();
    enable = 1'b0;
    t = 0;
    while (!(tvalid && tlast) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t5_last", 64'(tvalid && tlast), 64'd1);
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_fifo_left", 64'(fq[1].size()), 64'd3);
    exp_burst(1, 'h050, 'h010, 3, 3);
    tick();
    enable = 1'b1;
    wait_idle("t5_drain");
    enable = 1'b0;
    // overflow sticky set/clear
    tick(); full = 4'b0010;
    tick(); full = '0;
    @(negedge clk);
    chk("t6_sticky_set", 64'(sticky), 64'h2);
    repeat (3) tick();
    chk("t6_sticky_hold", 64'(sticky), 64'h2);
    clear_status = 1'b1;
    tick(); clear_status = 1'b0;
    chk("t6_sticky_clr", 64'(sticky), 64'h0);
    clear_status = 1'b1; full = 4'b0010;
    tick(); clear_status = 1'b0; full = '0;
    chk("t6_set_wins", 64'(sticky), 64'h2);
    // async reset during RD1
    load(3, 4, 'h7a0, 3);
    enable = 1'b1;
    wait_rd("t6_rd", 2);
    #1 rstn = 1'b0;
    #1;
    chk("t6_rst_rd_en", 64'(rd_en), 64'd0);
    chk("t6_rst_tvalid", 64'(tvalid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_sticky", 64'(sticky), 64'd0);
    chk("t6_rst_addr", 64'(addr), 64'd0);
    enable = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (4) tick();
    chk("t6_post_busy", 64'(busy), 64'd0);
    chk("t6_post_tvalid", 64'(tvalid), 64'd0);
    chk("t6_fifo_left", 64'(fq[3].size()), 64'd3);
    chk("t6_sb", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
